// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 8-to-1 mux.
// Latency: one edge from request to grant; one idle cycle after every release.
// Backpressure: the owner keeps the mux until done, req drop or the hold limit.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Counter value on the last permitted cycle of a grant.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       last_q, last_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             win_vld;
    logic [2:0]       win_idx;
    logic             rel_done, rel_drop, rel_lim, rel_any;

    // Find the first requester after the previous owner, wrapping round; the previous owner is searched last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] idx;
            idx = last_q + 3'(i);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Release causes for the current owner; timeout only flags the limit acting alone.
    always_comb begin
        rel_done = done;
        rel_drop = ~req[sel_q];
        rel_lim  = (cnt_q == HOLD_LAST);
        rel_any  = rel_done | rel_drop | rel_lim;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = OWN;
            OWN:     if (rel_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and priority pointer.
    always_comb begin
        sel_d     = sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d = 8'd1 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (rel_any) begin
                    grant_d   = 8'h00;
                    busy_d    = 1'b0;
                    last_d    = sel_q;
                    timeout_d = rel_lim & ~rel_done & ~rel_drop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output, counter and pointer registers; reset clears them without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 3'd0;
            grant_q   <= 8'h00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 3'd7;
        end else begin
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-to-1 multiplexer among eight requesters.
- Each requester drives one mux data input. The arbiter drives the mux select with the winning index and a one-hot grant.
- A grant is held until the owner releases it, or until a hold-limit timer forces release.
- Sits directly in front of the 8-to-1 mux. `sel` connects to the mux 3-bit select.

Parameters:
- MAX_HOLD, 15: maximum number of consecutive cycles one grant may stay asserted. Range 1..(2^CNT_W − 1). Must be ≥ 1.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; req[k] = requester k wants the mux.
- done  input  1  current owner releases the grant; sampled only while busy=1.
- sel  output  3  mux select = index of current/last owner.
- grant  output  8  one-hot grant. All zero when no owner.
- busy  output  1  1 while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - sel=3'd0, grant=8'h00, busy=0, timeout=0.
  - Hold counter = 0. Priority pointer last = 3'd7, so requester 0 has top priority after reset.
  - FSM = IDLE.
  - Asserting reset mid-grant drops grant and busy at once.
- FSM states: IDLE, OWN. All outputs are registered.
- Priority search: starting at index (last+1) mod 8, ascending with wrap, the first k with req[k]=1 wins.
- IDLE:
  - If req≠0 at an edge: grant=1<<k, sel=k, busy=1, counter=0, go to OWN.
  - Latency is one edge from request to grant.
  - If req=0: stay in IDLE, outputs unchanged. sel keeps its last value so the mux output stays stable.
  - done is ignored in IDLE.
- OWN (owner o = sel):
  - Each edge, release if any of these holds:
    - (a) done=1
    - (b) req[o]=0
    - (c) counter == MAX_HOLD−1
  - On release:
    - grant=0, busy=0, last=o, go to IDLE.
    - sel is unchanged.
    - timeout=1 only if (c) is the sole release cause. If (a) or (b) coincides with (c), timeout=0.
  - Otherwise: counter+1, grant/sel held.
  - Requests from non-owners are ignored while in OWN.
- Hold limit: grant is high for at most MAX_HOLD consecutive cycles. With MAX_HOLD=1, every grant lasts exactly one cycle.
- Turnaround: after any release there is exactly one idle cycle (grant=0) before the next grant. Grants never overlap, and grant is never non-one-hot.
- timeout is high for exactly the one cycle following the forcing edge, i.e. the first IDLE cycle. It is 0 at all other times.
- Fairness: a requester that holds req high continuously is granted within 7 other grants.

Test Plan:
1. Reset, then req=8'h01, done pulsed on the 3rd grant cycle → grant=8'h01 and sel=0 one edge after req; grant=8'h00 and busy=0 after the done edge; timeout stays 0.
2. req=8'hFF held constant, done=1 on every grant's first cycle → grants cycle 0,1,2,…,7,0, each one cycle long, each separated by one idle cycle; sel follows the index and holds its value during idle cycles.
3. MAX_HOLD=4, req=8'h10 held, done=0 → grant=8'h10 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then 8'h10 re-granted (sole requester).
4. Owner 3 is on its MAX_HOLD−1 cycle and done=1 at the same edge → release with timeout=0; next grant is the first requester above 3 with wrap (req=8'h09 → grant 8'h01).
5. rst_n pulled low mid-grant (grant=8'h20) between clock edges → grant=0, busy=0, sel=0 immediately. After release with req=8'h21, requester 0 wins.
6. Owner 5 drops req[5] while req[2]=1 → release at that edge, one idle cycle, then grant=8'h04, sel=2.
